// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake, flush and a zeroed control bubble.
// Define EX_MEM_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready; default is a single register.
module ex_mem_stage #(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 3,
    parameter int CTRL_W    = 17
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_LANES*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_LANES*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [1:0]                  occupancy
);

    localparam int PAY_W = NUM_LANES * DATA_W;

    logic [PAY_W-1:0]  head_data_q, head_data_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic              push;
    logic              pop;

`ifdef EX_MEM_STAGE_SKID_EN
    logic [PAY_W-1:0]  tail_data_q, tail_data_d;
    logic [CTRL_W-1:0] tail_ctrl_q, tail_ctrl_d;
    logic [1:0]        count_q, count_d;
    logic              in_ready_q, in_ready_d;

    assign push = in_valid & in_ready_q & ~flush;
    assign pop  = (count_q != 2'd0) & out_ready;

    // Head always feeds the output; tail only fills while the head is stalled.
    always_comb begin
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        tail_data_d = tail_data_q;
        tail_ctrl_d = tail_ctrl_q;
        count_d     = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                        count_d     = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end else if (push) begin
                        tail_data_d = in_data;
                        tail_ctrl_d = in_ctrl;
                        count_d     = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_data_d = tail_data_q;
                        head_ctrl_d = tail_ctrl_q;
                        count_d     = 2'd1;
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_data_q <= '0;
            head_ctrl_q <= '0;
            tail_data_q <= '0;
            tail_ctrl_q <= '0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
        end else begin
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
            tail_data_q <= tail_data_d;
            tail_ctrl_q <= tail_ctrl_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign occupancy = count_q;
`else
    logic valid_q, valid_d;

    assign in_ready = out_ready | ~valid_q;
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = valid_q & out_ready;

    always_comb begin
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        valid_d     = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (push) begin
            head_data_d = in_data;
            head_ctrl_d = in_ctrl;
            valid_d     = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_data_q <= '0;
            head_ctrl_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
            valid_q     <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign occupancy = {1'b0, valid_q};
`endif

    // A bubble must never carry write enables downstream.
    assign out_data = head_data_q;
    assign out_ctrl = out_valid ? head_ctrl_q : '0;

endmodule
